// File: rtl/mem_stage_vl_pkg.sv
// Shared definitions for the MEM stage: bus widths, field offsets, load opcodes
// and exception codes.
package mycpu_pkg;

    localparam int ES_BUS_WD = 147;
    localparam int MS_BUS_WD = 110;

    // EX->MEM bus field positions (lsb of each field)
    localparam int ES_RT_LSB   = 115;
    localparam int ES_PCERR    = 114;
    localparam int ES_BADV_LSB = 82;
    localparam int ES_EXC_LSB  = 77;
    localparam int ES_ERET     = 76;
    localparam int ES_BD       = 75;
    localparam int ES_LDOP_LSB = 72;
    localparam int ES_REQ      = 71;
    localparam int ES_RFM      = 70;
    localparam int ES_GRWE     = 69;
    localparam int ES_DEST_LSB = 64;
    localparam int ES_ALU_LSB  = 32;
    localparam int ES_PC_LSB   = 0;

    // MEM->WB bus field positions
    localparam int MS_PCERR    = 109;
    localparam int MS_BADV_LSB = 77;
    localparam int MS_EXC_LSB  = 72;
    localparam int MS_ERET     = 71;
    localparam int MS_BD       = 70;
    localparam int MS_GRWE     = 69;
    localparam int MS_DEST_LSB = 64;
    localparam int MS_RES_LSB  = 32;
    localparam int MS_PC_LSB   = 0;

    typedef enum logic [2:0] {
        LD_OP_LW  = 3'd0,
        LD_OP_LB  = 3'd1,
        LD_OP_LBU = 3'd2,
        LD_OP_LH  = 3'd3,
        LD_OP_LHU = 3'd4,
        LD_OP_LWL = 3'd5,
        LD_OP_LWR = 3'd6
    } ld_op_e;

    localparam logic [4:0] EXC_NONE = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

endpackage

// File: rtl/mem_stage_vl_if.sv
// Pipeline handshake and data-memory response signals seen by the MEM stage.
interface mem_stage_vl_if
    import mycpu_pkg::*;
#(
    parameter int ES_BUS_WD = mycpu_pkg::ES_BUS_WD,
    parameter int MS_BUS_WD = mycpu_pkg::MS_BUS_WD
);
    logic                 es_to_ms_valid;
    logic [ES_BUS_WD-1:0] es_to_ms_bus;
    logic                 ms_allowin;
    logic                 ws_allowin;
    logic                 ms_to_ws_valid;
    logic [MS_BUS_WD-1:0] ms_to_ws_bus;
    logic                 data_ok;
    logic [31:0]          data_rdata;

    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_ok, data_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus
    );

    modport master (
        output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_ok, data_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus
    );
endinterface

// File: rtl/mem_stage_vl_load_align.sv
// Combinational load data extraction: picks the byte/half/word lane and merges
// LWL/LWR partial words with the old rt value.
module load_align
    import mycpu_pkg::*;
(
    input  logic [2:0]  ld_op,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    input  logic [31:0] rt,
    output logic [31:0] result
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[7:0];
        case (off)
            2'd0: byte_v = rdata[7:0];
            2'd1: byte_v = rdata[15:8];
            2'd2: byte_v = rdata[23:16];
            2'd3: byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        half_v = off[1] ? rdata[31:16] : rdata[15:0];

        result = rdata;
        case (ld_op)
            LD_OP_LW:  result = rdata;
            LD_OP_LB:  result = {{24{byte_v[7]}}, byte_v};
            LD_OP_LBU: result = {24'h0, byte_v};
            LD_OP_LH:  result = {{16{half_v[15]}}, half_v};
            LD_OP_LHU: result = {16'h0, half_v};
            LD_OP_LWL: begin
                case (off)
                    2'd0: result = {rdata[7:0],  rt[23:0]};
                    2'd1: result = {rdata[15:0], rt[15:0]};
                    2'd2: result = {rdata[23:0], rt[7:0]};
                    default: result = rdata;
                endcase
            end
            LD_OP_LWR: begin
                case (off)
                    2'd0: result = rdata;
                    2'd1: result = {rt[31:24], rdata[31:8]};
                    2'd2: result = {rt[31:16], rdata[31:16]};
                    default: result = {rt[31:8], rdata[31:24]};
                endcase
            end
            default: result = rdata;
        endcase
    end
endmodule

// File: rtl/mem_stage_vl.sv
// MEM stage for a variable-latency data memory; drops responses owed by flushed
// loads. Define MS_LOAD_ALIGN_EXC_EN to raise AdEL on misaligned LW/LH/LHU.
module mem_stage_vl
    import mycpu_pkg::*;
#(
    parameter int ES_BUS_WD       = mycpu_pkg::ES_BUS_WD,
    parameter int MS_BUS_WD       = mycpu_pkg::MS_BUS_WD,
    parameter int MAX_OUTSTANDING = 2
)(
    input  logic           clk,
    input  logic           reset,
    mem_stage_vl_if.slave  ms_if,
    input  logic           flush,
    output logic [4:0]     ms_fwd_dest,
    output logic [31:0]    ms_fwd_data,
    output logic           ms_fwd_stall,
    output logic           ms_ex,
    output logic           ms_eret
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic                 ms_valid;
    logic [ES_BUS_WD-1:0] bus_r;
    logic                 buf_valid;
    logic [31:0]          buf_data;
    logic [CNT_W-1:0]     discard_cnt;

    logic [31:0] rt_value, badv_in, alu_result, pc;
    logic [4:0]  exc_in, dest;
    logic [2:0]  ld_op;
    logic        pc_error, eret, bd, req_issued, res_from_mem, gr_we_in;

    assign rt_value     = bus_r[ES_RT_LSB +: 32];
    assign pc_error     = bus_r[ES_PCERR];
    assign badv_in      = bus_r[ES_BADV_LSB +: 32];
    assign exc_in       = bus_r[ES_EXC_LSB +: 5];
    assign eret         = bus_r[ES_ERET];
    assign bd           = bus_r[ES_BD];
    assign ld_op        = bus_r[ES_LDOP_LSB +: 3];
    assign req_issued   = bus_r[ES_REQ];
    assign res_from_mem = bus_r[ES_RFM];
    assign gr_we_in     = bus_r[ES_GRWE];
    assign dest         = bus_r[ES_DEST_LSB +: 5];
    assign alu_result   = bus_r[ES_ALU_LSB +: 32];
    assign pc           = bus_r[ES_PC_LSB +: 32];

    logic need_rsp, rsp_hit, ms_ready_go, ms_allowin;
    logic discard_inc, discard_dec;

    assign need_rsp    = ms_valid && req_issued;
    assign rsp_hit     = ms_if.data_ok && (discard_cnt == '0);
    assign ms_ready_go = !need_rsp || buf_valid || rsp_hit;
    assign ms_allowin  = !ms_valid || (ms_ready_go && ms_if.ws_allowin);
    assign discard_dec = ms_if.data_ok && (discard_cnt != '0);
    // A flushed load that has neither been answered nor buffered leaves a stale response in flight
    assign discard_inc = flush && need_rsp && !buf_valid && !rsp_hit;

    assign ms_if.ms_allowin     = ms_allowin;
    assign ms_if.ms_to_ws_valid = ms_valid && ms_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid  <= 1'b0;
            bus_r     <= '0;
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else if (flush) begin
            ms_valid  <= 1'b0;
            buf_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid  <= ms_if.es_to_ms_valid;
            buf_valid <= 1'b0;
            if (ms_if.es_to_ms_valid) begin
                bus_r <= ms_if.es_to_ms_bus;
            end
        end else if (need_rsp && rsp_hit && !buf_valid && !ms_if.ws_allowin) begin
            buf_valid <= 1'b1;
            buf_data  <= ms_if.data_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            discard_cnt <= '0;
        end else if (discard_inc && !discard_dec) begin
            if (discard_cnt != CNT_MAX) begin
                discard_cnt <= discard_cnt + 1'b1;
            end
        end else if (discard_dec && !discard_inc) begin
            discard_cnt <= discard_cnt - 1'b1;
        end
    end

    a_discard_bound: assert property (@(posedge clk) disable iff (reset)
        (discard_cnt <= CNT_MAX) && !(discard_inc && !discard_dec && discard_cnt == CNT_MAX));

    logic [31:0] ld_rdata, ld_result, final_result;

    assign ld_rdata = buf_valid ? buf_data : ms_if.data_rdata;

    load_align u_load_align (
        .ld_op  (ld_op),
        .off    (alu_result[1:0]),
        .rdata  (ld_rdata),
        .rt     (rt_value),
        .result (ld_result)
    );

    assign final_result = res_from_mem ? ld_result : alu_result;

    logic ade;
`ifdef MS_LOAD_ALIGN_EXC_EN
    assign ade = res_from_mem && (exc_in == EXC_NONE) &&
                 (((ld_op == LD_OP_LW) && (alu_result[1:0] != 2'b00)) ||
                  (((ld_op == LD_OP_LH) || (ld_op == LD_OP_LHU)) && alu_result[0]));
`else
    assign ade = 1'b0;
`endif

    logic [4:0]  exc_out;
    logic [31:0] badv_out;
    logic        gr_we_out;

    assign exc_out   = ade ? EXC_ADEL : exc_in;
    assign badv_out  = ade ? alu_result : badv_in;
    assign gr_we_out = gr_we_in && !ade;

    always_comb begin
        ms_if.ms_to_ws_bus                       = '0;
        ms_if.ms_to_ws_bus[MS_PCERR]             = pc_error;
        ms_if.ms_to_ws_bus[MS_BADV_LSB +: 32]    = badv_out;
        ms_if.ms_to_ws_bus[MS_EXC_LSB +: 5]      = exc_out;
        ms_if.ms_to_ws_bus[MS_ERET]              = eret;
        ms_if.ms_to_ws_bus[MS_BD]                = bd;
        ms_if.ms_to_ws_bus[MS_GRWE]              = gr_we_out;
        ms_if.ms_to_ws_bus[MS_DEST_LSB +: 5]     = dest;
        ms_if.ms_to_ws_bus[MS_RES_LSB +: 32]     = final_result;
        ms_if.ms_to_ws_bus[MS_PC_LSB +: 32]      = pc;
    end

    assign ms_fwd_dest  = (ms_valid && gr_we_out) ? dest : 5'd0;
    assign ms_fwd_data  = ms_valid ? final_result : 32'd0;
    assign ms_fwd_stall = ms_valid && res_from_mem && !ms_ready_go;
    assign ms_ex        = ms_valid && (exc_out != EXC_NONE);
    assign ms_eret      = ms_valid && eret;
endmodule

// File: tb/tb_mem_stage_vl.sv
// Directed self-checking bench for mem_stage_vl: load extraction, latency,
// WB back-pressure buffering, stale-response discard and optional AdEL check.
module tb_mem_stage_vl;
    import mycpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [4:0]  ms_fwd_dest;
    logic [31:0] ms_fwd_data;
    logic        ms_fwd_stall;
    logic        ms_ex;
    logic        ms_eret;

    always #5 clk = ~clk;

    mem_stage_vl_if #(.ES_BUS_WD(ES_BUS_WD), .MS_BUS_WD(MS_BUS_WD)) bus_if ();

    mem_stage_vl #(.ES_BUS_WD(ES_BUS_WD), .MS_BUS_WD(MS_BUS_WD), .MAX_OUTSTANDING(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .ms_if        (bus_if),
        .flush        (flush),
        .ms_fwd_dest  (ms_fwd_dest),
        .ms_fwd_data  (ms_fwd_data),
        .ms_fwd_stall (ms_fwd_stall),
        .ms_ex        (ms_ex),
        .ms_eret      (ms_eret)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [146:0] mk(input logic [31:0] rt, input logic [2:0] op,
                                        input logic req, input logic rfm, input logic we,
                                        input logic [4:0] dst, input logic [31:0] alu,
                                        input logic [31:0] pc, input logic [4:0] exc,
                                        input logic er);
        mk = {rt, 1'b0, 32'h0, exc, er, 1'b0, op, req, rfm, we, dst, alu, pc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [146:0] b);
        check("accept_ready", bus_if.ms_allowin, 1'b1);
        bus_if.es_to_ms_valid = 1'b1;
        bus_if.es_to_ms_bus   = b;
        step();
        bus_if.es_to_ms_valid = 1'b0;
    endtask

    function automatic logic [31:0] res();
        res = bus_if.ms_to_ws_bus[63:32];
    endfunction

    logic [2:0]  t_op  [9] = '{3'd0, 3'd2, 3'd1, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6};
    logic [31:0] t_alu [9] = '{32'h100, 32'h103, 32'h103, 32'h102, 32'h100,
                               32'h100, 32'h102, 32'h103, 32'h102};
    logic [31:0] t_exp [9] = '{32'h87654321, 32'h00000087, 32'hFFFFFF87, 32'hFFFF8765,
                               32'h00004321, 32'h21BBCCDD, 32'h654321DD, 32'hAABBCC87,
                               32'hAABB8765};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int handoffs;
        reset = 1'b1;
        flush = 1'b0;
        bus_if.es_to_ms_valid = 1'b0;
        bus_if.es_to_ms_bus   = '0;
        bus_if.ws_allowin     = 1'b1;
        bus_if.data_ok        = 1'b0;
        bus_if.data_rdata     = '0;
        repeat (3) step();
        reset = 1'b0;
        #2;
        check("rst_allowin", bus_if.ms_allowin, 1'b1);
        check("rst_valid", bus_if.ms_to_ws_valid, 1'b0);
        check("rst_bus", bus_if.ms_to_ws_bus, 0);
        check("rst_fwd_dest", ms_fwd_dest, 0);
        check("rst_fwd_data", ms_fwd_data, 0);
        check("rst_stall", ms_fwd_stall, 0);
        check("rst_ex", ms_ex, 0);
        check("rst_eret", ms_eret, 0);

        // LB with a three-cycle response latency
        issue(mk(32'h0, 3'd1, 1'b1, 1'b1, 1'b1, 5'd5, 32'h1002, 32'hBFC00100, 5'h0, 1'b0));
        for (int c = 0; c < 3; c++) begin
            #2;
            check($sformatf("lb_stall%0d", c), ms_fwd_stall, 1'b1);
            check($sformatf("lb_wait%0d", c), bus_if.ms_to_ws_valid, 1'b0);
            step();
        end
        bus_if.data_ok = 1'b1;
        bus_if.data_rdata = 32'h12F45678;
        #2;
        check("lb_stall_end", ms_fwd_stall, 1'b0);
        check("lb_valid", bus_if.ms_to_ws_valid, 1'b1);
        check("lb_result", res(), 32'hFFFFFFF4);
        check("lb_fwd_data", ms_fwd_data, 32'hFFFFFFF4);
        check("lb_fwd_dest", ms_fwd_dest, 5'd5);
        step();
        bus_if.data_ok = 1'b0;
        #2;
        check("lb_gone", bus_if.ms_to_ws_valid, 1'b0);
        step();

        // Extraction table, rt=AABBCCDD, rdata=87654321, zero-latency response
        for (int i = 0; i < 9; i++) begin
            issue(mk(32'hAABBCCDD, t_op[i], 1'b1, 1'b1, 1'b1, 5'd3, t_alu[i], 32'h200, 5'h0, 1'b0));
            bus_if.data_ok = 1'b1;
            bus_if.data_rdata = 32'h87654321;
            #2;
            check($sformatf("ext%0d_valid", i), bus_if.ms_to_ws_valid, 1'b1);
            check($sformatf("ext%0d_result", i), res(), t_exp[i]);
            step();
            bus_if.data_ok = 1'b0;
        end

        // LWR / LWL at offset 1
        issue(mk(32'hAABBCCDD, 3'd6, 1'b1, 1'b1, 1'b1, 5'd4, 32'h2001, 32'h300, 5'h0, 1'b0));
        bus_if.data_ok = 1'b1;
        bus_if.data_rdata = 32'h11223344;
        #2;
        check("lwr_result", res(), 32'hAA112233);
        step();
        bus_if.data_ok = 1'b0;
        issue(mk(32'hAABBCCDD, 3'd5, 1'b1, 1'b1, 1'b1, 5'd4, 32'h2001, 32'h304, 5'h0, 1'b0));
        bus_if.data_ok = 1'b1;
        bus_if.data_rdata = 32'h11223344;
        #2;
        check("lwl_result", res(), 32'h3344CCDD);
        step();
        bus_if.data_ok = 1'b0;

        // Response arrives while WB stalls
        issue(mk(32'h0, 3'd0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h3000, 32'h400, 5'h0, 1'b0));
        bus_if.ws_allowin = 1'b0;
        bus_if.data_ok = 1'b1;
        bus_if.data_rdata = 32'hDEADBEEF;
        #2;
        check("buf_valid0", bus_if.ms_to_ws_valid, 1'b1);
        check("buf_allowin0", bus_if.ms_allowin, 1'b0);
        step();
        bus_if.data_ok = 1'b0;
        bus_if.data_rdata = 32'h0;
        for (int k = 0; k < 3; k++) begin
            #2;
            check($sformatf("buf_hold%0d", k), res(), 32'hDEADBEEF);
            check($sformatf("buf_hold_valid%0d", k), bus_if.ms_to_ws_valid, 1'b1);
            step();
        end
        bus_if.ws_allowin = 1'b1;
        handoffs = 0;
        for (int k = 0; k < 4; k++) begin
            #2;
            if (bus_if.ms_to_ws_valid && bus_if.ws_allowin) begin
                handoffs++;
                check("buf_release", res(), 32'hDEADBEEF);
            end
            step();
        end
        check("buf_once", handoffs, 1);

        // Flush with a load pending leaves one stale response to drop
        issue(mk(32'h0, 3'd0, 1'b1, 1'b1, 1'b1, 5'd8, 32'h4000, 32'h500, 5'h0, 1'b0));
        #2;
        check("fl_pending", ms_fwd_stall, 1'b1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #2;
        check("fl_cnt1", dut.discard_cnt, 1);
        check("fl_valid", bus_if.ms_to_ws_valid, 1'b0);
        check("fl_allowin", bus_if.ms_allowin, 1'b1);
        issue(mk(32'h0, 3'd0, 1'b1, 1'b1, 1'b1, 5'd9, 32'h5000, 32'h600, 5'h0, 1'b0));
        bus_if.data_ok = 1'b1;
        bus_if.data_rdata = 32'h11111111;
        #2;
        check("fl_stale_valid", bus_if.ms_to_ws_valid, 1'b0);
        check("fl_stale_stall", ms_fwd_stall, 1'b1);
        step();
        bus_if.data_rdata = 32'h22222222;
        #2;
        check("fl_cnt0", dut.discard_cnt, 0);
        check("fl_new_valid", bus_if.ms_to_ws_valid, 1'b1);
        check("fl_new_result", res(), 32'h22222222);
        step();
        bus_if.data_ok = 1'b0;

        // Flush in the same cycle as the response: nothing owed afterwards
        issue(mk(32'h0, 3'd0, 1'b1, 1'b1, 1'b1, 5'd11, 32'h6000, 32'h700, 5'h0, 1'b0));
        bus_if.data_ok = 1'b1;
        bus_if.data_rdata = 32'h33333333;
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus_if.data_ok = 1'b0;
        #2;
        check("sf_cnt", dut.discard_cnt, 0);
        check("sf_valid", bus_if.ms_to_ws_valid, 1'b0);
        check("sf_fwd_dest", ms_fwd_dest, 0);
        step();
        issue(mk(32'h0, 3'd0, 1'b1, 1'b1, 1'b1, 5'd12, 32'h7000, 32'h800, 5'h0, 1'b0));
        bus_if.data_ok = 1'b1;
        bus_if.data_rdata = 32'h44444444;
        #2;
        check("sf_next_result", res(), 32'h44444444);
        step();
        bus_if.data_ok = 1'b0;

        // Non-memory instructions: exception and ERET pass straight through
        issue(mk(32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h12345678, 32'h900, 5'h0c, 1'b0));
        #2;
        check("ex_flag", ms_ex, 1'b1);
        check("ex_valid", bus_if.ms_to_ws_valid, 1'b1);
        check("ex_result", res(), 32'h12345678);
        check("ex_code", bus_if.ms_to_ws_bus[76:72], 5'h0c);
        step();
        issue(mk(32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'hA00, 5'h0, 1'b1));
        #2;
        check("eret_flag", ms_eret, 1'b1);
        check("eret_noex", ms_ex, 1'b0);
        step();

        // Misaligned LW
        issue(mk(32'h0, 3'd0, 1'b1, 1'b1, 1'b1, 5'd10, 32'h1002, 32'hB00, 5'h0, 1'b0));
        #2;
        check("al_wait", bus_if.ms_to_ws_valid, 1'b0);
        step();
        bus_if.data_ok = 1'b1;
        bus_if.data_rdata = 32'hCAFEF00D;
        #2;
        check("al_valid", bus_if.ms_to_ws_valid, 1'b1);
        check("al_result", res(), 32'hCAFEF00D);
`ifdef MS_LOAD_ALIGN_EXC_EN
        check("al_exc", bus_if.ms_to_ws_bus[76:72], 5'h04);
        check("al_badv", bus_if.ms_to_ws_bus[108:77], 32'h1002);
        check("al_gr_we", bus_if.ms_to_ws_bus[69], 1'b0);
        check("al_ms_ex", ms_ex, 1'b1);
`else
        check("al_exc", bus_if.ms_to_ws_bus[76:72], 5'h00);
        check("al_badv", bus_if.ms_to_ws_bus[108:77], 32'h0);
        check("al_gr_we", bus_if.ms_to_ws_bus[69], 1'b1);
        check("al_ms_ex", ms_ex, 1'b0);
`endif
        step();
        bus_if.data_ok = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
